// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and arbiter state encoding.
package vga_pkg;

  localparam int unsigned FB_W          = 160;
  localparam int unsigned FB_H          = 120;
  localparam int unsigned SCALE_SH      = 2;
  localparam int unsigned ROW_STRIDE_SH = 8;

  typedef enum logic [1:0] {
    IDLE,
    DISP_RD,
    DISP_CAP,
    WR
  } state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Time-shares a single-port frame-buffer RAM between display scanout (fixed
// priority, one read per 4-pixel group) and a drawing-engine write port, and
// delays the syncs by one strobe to line up with the registered pixel.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              in_clock,
  input  logic              in_reset,
  input  logic              in_strobe,
  input  logic              in_active,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic [9:0]        in_x,
  input  logic [8:0]        in_y,
  input  logic              in_wr_req,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0] in_wr_data,
  output logic              out_wr_ack,
  output logic              out_wr_err,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_we,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_hsync,
  output logic              out_vsync
);

  state_t                          state;
  state_t                          state_nx;
  logic                            pend;
  logic [ADDR_W-1:0]               disp_addr;
  logic [DATA_W-1:0]               fetch;
  logic                            disp_req;
  logic                            wr_in_range;
  logic [ADDR_W-ROW_STRIDE_SH-1:0] wr_row;
  logic [ROW_STRIDE_SH-1:0]        wr_col;
  logic                            unused_y;

  // A group fetch is requested on the first pixel of every visible 4-pixel group.
  assign disp_req = in_strobe & in_active & (in_x[SCALE_SH-1:0] == '0);

  assign {wr_row, wr_col} = in_wr_addr;
  assign wr_in_range = (32'(wr_row) < FB_H) && (32'(wr_col) < FB_W);

  // Sub-group row bits select nothing: rows are replicated by the 4x scale.
  assign unused_y = ^in_y[SCALE_SH-1:0];

  // Arbiter state register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state <= IDLE;
    else          state <= state_nx;
  end

  // Display request latch: set on a group strobe, cleared when the read is issued.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      pend      <= 1'b0;
      disp_addr <= '0;
    end else if (disp_req) begin
      pend      <= 1'b1;
      disp_addr <= ADDR_W'({in_y[8:SCALE_SH], in_x[9:SCALE_SH]});
    end else if (state_nx == DISP_RD) begin
      pend      <= 1'b0;
    end
  end

  // Capture the RAM read data one cycle after the display address was presented.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset)               fetch <= '0;
    else if (state == DISP_CAP) fetch <= in_mem_rdata;
  end

  // Pixel and sync output registers, advanced once per pixel strobe.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      out_pixel <= '0;
      out_hsync <= 1'b1;
      out_vsync <= 1'b1;
    end else if (in_strobe) begin
      out_pixel <= in_active ? fetch : '0;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
    end
  end

  // Next-state and RAM port drive; display always preempts a waiting write.
  always_comb begin
    state_nx      = state;
    out_mem_addr  = '0;
    out_mem_we    = 1'b0;
    out_mem_wdata = '0;
    out_wr_ack    = 1'b0;
    out_wr_err    = 1'b0;
    case (state)
      IDLE: begin
        if (pend)           state_nx = DISP_RD;
        else if (in_wr_req) state_nx = WR;
      end
      DISP_RD: begin
        state_nx     = DISP_CAP;
        out_mem_addr = disp_addr;
      end
      DISP_CAP: begin
        state_nx = in_wr_req ? WR : IDLE;
      end
      WR: begin
        state_nx      = pend ? DISP_RD : IDLE;
        out_mem_addr  = in_wr_addr;
        out_mem_wdata = in_wr_data;
        out_wr_ack    = 1'b1;
        out_mem_we    = wr_in_range;
        out_wr_err    = ~wr_in_range;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized scanout/write
// mix checked against a frame-buffer reference built from the addressing rules.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          strobe  = 1'b0;
  logic          active  = 1'b0;
  logic          hsync   = 1'b1;
  logic          vsync   = 1'b1;
  logic [9:0]    x       = '0;
  logic [8:0]    y       = '0;
  logic          wr_req  = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, wr_err, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, pixel;
  logic          pix_hsync, pix_vsync;
  logic          preload = 1'b1;
  logic [DW-1:0] ram [DEPTH];

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] ref_wr [int];

  always #5 clk = ~clk;

  vram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .in_clock(clk), .in_reset(rst), .in_strobe(strobe), .in_active(active),
    .in_hsync(hsync), .in_vsync(vsync), .in_x(x), .in_y(y),
    .in_wr_req(wr_req), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
    .out_wr_ack(wr_ack), .out_wr_err(wr_err), .out_mem_addr(mem_addr),
    .out_mem_we(mem_we), .out_mem_wdata(mem_wdata), .in_mem_rdata(mem_rdata),
    .out_pixel(pixel), .out_hsync(pix_hsync), .out_vsync(pix_vsync)
  );

  // Frame-buffer RAM, one-cycle read latency, preloaded with the column byte.
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < int'(DEPTH); i++) ram[i] <= DW'(i % 256);
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] ref_read(input int a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return DW'(a % 256);
  endfunction

  function automatic int group_addr(input int px, input int py);
    return (py / 4) * 256 + px / 4;
  endfunction

  function automatic logic out_of_range(input int a);
    return (a / 256 >= int'(FB_H)) || (a % 256 >= int'(FB_W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_strobe(input int px, input int py, input logic act,
                              input logic hs, input logic vs);
    strobe = 1'b1; x = 10'(px); y = 9'(py); active = act; hsync = hs; vsync = vs;
    tick();
    strobe = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (pixel !== '0) begin failures++; $display("FAIL reset_pixel got=%0h exp=0", pixel); end
    checks++; if ({pix_hsync, pix_vsync} !== 2'b11) begin failures++; $display("FAIL reset_sync got=%b exp=11", {pix_hsync, pix_vsync}); end
    checks++; if ({wr_ack, wr_err, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {wr_ack, wr_err, mem_we}); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", mem_wdata); end
    tick(); tick();
    preload = 1'b0;
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_scanout();
    drive_strobe(8, 4, 1'b1, 1'b1, 1'b1);
    tick();
    checks++; if (mem_addr !== 15'h0102) begin failures++; $display("FAIL scan_addr got=%0h exp=102", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL scan_we got=%b exp=0", mem_we); end
    tick(); tick();
    for (int k = 1; k <= 4; k++) begin
      drive_strobe(8 + k, 4, 1'b1, (k == 4) ? 1'b0 : 1'b1, (k == 4) ? 1'b0 : 1'b1);
      checks++; if (pixel !== 8'h02) begin failures++; $display("FAIL scan_pixel%0d got=%0h exp=02", k, pixel); end
      checks++; if ({pix_hsync, pix_vsync} !== ((k == 4) ? 2'b00 : 2'b11)) begin
        failures++; $display("FAIL scan_sync%0d got=%b exp=%b", k, {pix_hsync, pix_vsync}, (k == 4) ? 2'b00 : 2'b11);
      end
      if (k < 4) begin tick(); tick(); tick(); end
    end
  endtask

  task automatic test_reset_midframe();
    #3 rst = 1'b1;
    #1;
    checks++; if (pixel !== '0) begin failures++; $display("FAIL mid_reset_pixel got=%0h exp=0", pixel); end
    checks++; if ({pix_hsync, pix_vsync} !== 2'b11) begin failures++; $display("FAIL mid_reset_sync got=%b exp=11", {pix_hsync, pix_vsync}); end
    checks++; if ({wr_ack, wr_err, mem_we, mem_addr} !== '0) begin failures++; $display("FAIL mid_reset_port got=%0h exp=0", {wr_ack, wr_err, mem_we, mem_addr}); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    drive_strobe(13, 4, 1'b1, 1'b1, 1'b1);
    checks++; if (pixel !== '0) begin failures++; $display("FAIL post_reset_pixel got=%0h exp=0", pixel); end
    tick(); tick(); tick();
  endtask

  task automatic test_contention();
    drive_strobe(8, 0, 1'b1, 1'b1, 1'b1);
    wr_req = 1'b1; wr_addr = '0; wr_data = 8'h55;
    tick();
    checks++; if ({mem_addr, mem_we, wr_ack} !== {15'h0002, 2'b00}) begin failures++; $display("FAIL cont_disp got=%0h exp=%0h", {mem_addr, mem_we, wr_ack}, {15'h0002, 2'b00}); end
    tick();
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL cont_cap_ack got=%b exp=0", wr_ack); end
    tick();
    checks++; if ({wr_ack, wr_err, mem_we, mem_addr, mem_wdata} !== {3'b101, 15'h0000, 8'h55}) begin
      failures++; $display("FAIL cont_wr got=%0h exp=%0h", {wr_ack, wr_err, mem_we, mem_addr, mem_wdata}, {3'b101, 15'h0000, 8'h55});
    end
    tick();
    wr_req = 1'b0;
    ref_wr[0] = 8'h55;
    checks++; if (ram[0] !== 8'h55) begin failures++; $display("FAIL cont_ram got=%0h exp=55", ram[0]); end
    tick(); tick();
  endtask

  task automatic test_range();
    logic [AW-1:0] addrs [4] = '{15'h7800, 15'h00A0, 15'h779F, 15'h7FFF};
    logic          errs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int unsigned waited;
      waited  = 0;
      wr_req  = 1'b1; wr_addr = addrs[i]; wr_data = DW'($urandom);
      tick();
      while (wr_ack !== 1'b1 && waited < 6) begin tick(); waited++; end
      checks++;
      if (wr_ack !== 1'b1) begin
        failures++; $display("FAIL range_timeout%0d got=%b exp=1", i, wr_ack);
      end else begin
        checks++; if ({wr_err, mem_we} !== {errs[i], ~errs[i]}) begin failures++; $display("FAIL range_err%0d got=%b exp=%b", i, {wr_err, mem_we}, {errs[i], ~errs[i]}); end
        checks++; if (mem_addr !== addrs[i]) begin failures++; $display("FAIL range_addr%0d got=%0h exp=%0h", i, mem_addr, addrs[i]); end
      end
      if (!errs[i]) ref_wr[int'(addrs[i])] = wr_data;
      tick();
      wr_req = 1'b0;
      checks++; if (ram[addrs[i]] !== ref_read(int'(addrs[i]))) begin failures++; $display("FAIL range_ram%0d got=%0h exp=%0h", i, ram[addrs[i]], ref_read(int'(addrs[i]))); end
      tick();
    end
  endtask

  task automatic test_blanking();
    int   last_ack = -1;
    int   n_ack    = 0;
    logic retire   = 1'b0;
    logic s_valid  = 1'b0;
    logic [1:0] s_sync = 2'b11;
    active  = 1'b0;
    wr_req  = 1'b1;
    wr_addr = AW'((2 + $urandom_range(117)) * 256 + $urandom_range(159));
    wr_data = DW'($urandom);
    for (int c = 0; c < 48; c++) begin
      tick();
      if (s_valid) begin
        checks++; if (pixel !== '0) begin failures++; $display("FAIL blank_pixel c=%0d got=%0h exp=0", c, pixel); end
        checks++; if ({pix_hsync, pix_vsync} !== s_sync) begin failures++; $display("FAIL blank_sync c=%0d got=%b exp=%b", c, {pix_hsync, pix_vsync}, s_sync); end
      end
      if (wr_ack) begin
        if (last_ack >= 0) begin
          checks++; if (c - last_ack != 2) begin failures++; $display("FAIL blank_gap got=%0d exp=2", c - last_ack); end
        end
        ref_wr[int'(wr_addr)] = wr_data;
        last_ack = c; n_ack++; retire = 1'b1;
      end else if (retire) begin
        wr_addr = AW'((2 + $urandom_range(117)) * 256 + $urandom_range(159));
        wr_data = DW'($urandom);
        retire  = 1'b0;
      end
      s_valid = 1'b0;
      if (c % 4 == 1) begin
        s_sync = 2'($urandom_range(3));
        strobe = 1'b1; x = 10'($urandom_range(639)); hsync = s_sync[1]; vsync = s_sync[0];
        s_valid = 1'b1;
      end else begin
        strobe = 1'b0;
      end
    end
    wr_req = 1'b0; strobe = 1'b0; hsync = 1'b1; vsync = 1'b1;
    checks++; if (n_ack != 24) begin failures++; $display("FAIL blank_acks got=%0d exp=24", n_ack); end
    tick(); tick();
  endtask

  task automatic test_reset_during_wr();
    int unsigned   waited = 0;
    int            acks   = 0;
    logic [DW-1:0] d;
    d = DW'($urandom);
    wr_req = 1'b1; wr_addr = 15'h0305; wr_data = d;
    tick();
    while (wr_ack !== 1'b1 && waited < 6) begin tick(); waited++; end
    checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL rstwr_first_ack got=%b exp=1", wr_ack); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({wr_ack, mem_we} !== 2'b00) begin failures++; $display("FAIL rstwr_abort got=%b exp=00", {wr_ack, mem_we}); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (wr_ack) begin
        acks++;
        tick();
        wr_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    ref_wr[16'h0305] = d;
    checks++; if (acks != 1) begin failures++; $display("FAIL rstwr_acks got=%0d exp=1", acks); end
    checks++; if (ram[15'h0305] !== d) begin failures++; $display("FAIL rstwr_ram got=%0h exp=%0h", ram[15'h0305], d); end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] fetched = '0;
    logic [DW-1:0] exp_pix;
    logic          s_valid = 1'b0;
    logic          s_act   = 1'b0;
    logic [1:0]    s_sync  = 2'b11;
    int            s_x = 0, s_y = 0, xpos = 0, ypos = 0;
    int            waited = 0, n_ack = 0;
    logic          retire = 1'b0;
    logic          exp_err;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (s_valid) begin
        exp_pix = s_act ? fetched : '0;
        checks++; if (pixel !== exp_pix) begin failures++; $display("FAIL rnd_pixel c=%0d x=%0d got=%0h exp=%0h", c, s_x, pixel, exp_pix); end
        checks++; if ({pix_hsync, pix_vsync} !== s_sync) begin failures++; $display("FAIL rnd_sync c=%0d got=%b exp=%b", c, {pix_hsync, pix_vsync}, s_sync); end
        if (s_act && s_x % 4 == 0) fetched = ref_read(group_addr(s_x, s_y));
      end
      if (wr_req && !retire) begin
        if (wr_ack) begin
          exp_err = out_of_range(int'(wr_addr));
          checks++; if ({mem_addr, mem_wdata} !== {wr_addr, wr_data}) begin failures++; $display("FAIL rnd_wr_port got=%0h exp=%0h", {mem_addr, mem_wdata}, {wr_addr, wr_data}); end
          checks++; if ({wr_err, mem_we} !== {exp_err, ~exp_err}) begin failures++; $display("FAIL rnd_wr_err addr=%0h got=%b exp=%b", wr_addr, {wr_err, mem_we}, {exp_err, ~exp_err}); end
          if (!exp_err) ref_wr[int'(wr_addr)] = wr_data;
          retire = 1'b1; n_ack++;
        end else begin
          waited++;
          checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rnd_we_no_ack got=%b exp=0", mem_we); end
          if (waited > 6) begin
            checks++; failures++;
            $display("FAIL rnd_wr_timeout waited=%0d exp<=6", waited);
            wr_req = 1'b0;
          end
        end
      end else begin
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL rnd_spurious_ack got=%b exp=0", wr_ack); end
      end
      if (retire) begin
        wr_req = 1'b0; retire = 1'b0;
      end else if (!wr_req && $urandom_range(2) == 0) begin
        wr_req  = 1'b1;
        wr_addr = AW'((2 + $urandom_range(125)) * 256 + $urandom_range(255));
        wr_data = DW'($urandom);
        waited  = 0;
      end
      s_valid = 1'b0;
      if (c % 4 == 0) begin
        s_x = xpos; s_y = ypos;
        s_act  = ($urandom_range(3) != 0);
        s_sync = 2'($urandom_range(3));
        strobe = 1'b1; x = 10'(s_x); y = 9'(s_y); active = s_act;
        hsync  = s_sync[1]; vsync = s_sync[0];
        s_valid = 1'b1;
        xpos++;
        if (xpos % 16 == 0) begin
          xpos = 4 * int'($urandom_range(155));
          ypos = int'($urandom_range(7));
        end
      end else begin
        strobe = 1'b0;
      end
    end
    strobe = 1'b0; wr_req = 1'b0;
    checks++; if (n_ack < 40) begin failures++; $display("FAIL rnd_throughput got=%0d exp>=40", n_ack); end
  endtask

  initial begin
    test_reset();
    test_scanout();
    test_reset_midframe();
    test_contention();
    test_range();
    test_blanking();
    test_reset_during_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
